// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, 1-cycle-read-latency memory between the
//   instruction-fetch port and the data port. The arbiter grants at most one
//   access per cycle, and the data port has priority. For stores it builds the
//   byte-lane enables and replicated write data. For loads it selects and
//   extends the addressed byte or halfword. A grant in cycle N gives a response
//   pulse in cycle N+1, and a new grant can be made in that same cycle.
//
//   Optional feature: define MEM_ARB_STARVE_GUARD_EN to build a fetch
//   anti-starvation counter. After four consecutive data grants made while a
//   fetch was waiting, the next grant goes to fetch.

module mem_port_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,

  // Instruction-fetch port
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic [DATA_LEN-1:0] if_rdata,
  output logic                if_valid,

  // Data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [2:0]          d_fn,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic [DATA_LEN-1:0] d_wdata,
  output logic [DATA_LEN-1:0] d_rdata,
  output logic                d_valid,
  output logic                d_misalign,

  // Unified memory
  output logic                m_en,
  output logic                m_we,
  output logic [3:0]          m_be,
  output logic [ADDR_LEN-1:0] m_addr,
  output logic [DATA_LEN-1:0] m_wdata,
  input  logic [DATA_LEN-1:0] m_rdata,

  // Pipeline freeze
  output logic                cpu_stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // funct3 load/store encodings
  localparam logic [2:0] FN_B  = 3'b000;
  localparam logic [2:0] FN_H  = 3'b001;
  localparam logic [2:0] FN_BU = 3'b100;
  localparam logic [2:0] FN_HU = 3'b101;

  // Access size from funct3. Codes 011, 110 and 111 fall through to word.
  function automatic size_t fn_size(input logic [2:0] fn);
    case (fn)
      FN_B, FN_BU: fn_size = SZ_B;
      FN_H, FN_HU: fn_size = SZ_H;
      default:     fn_size = SZ_W;
    endcase
  endfunction

  state_t      state_q, state_d;

  // Response context captured at grant time. Later changes on the data inputs
  // do not affect the extraction done in the response cycle.
  logic [1:0]  rsp_off_q;
  logic [2:0]  rsp_fn_q;
  logic        rsp_store_q;
  logic        rsp_mis_q;

  logic        if_elig;
  logic        d_elig;
  logic        grant_d;
  logic        grant_if;
  logic        starve_force;
  size_t       d_size;
  logic        d_mis;

  // The fetch address is word-aligned by contract, so its low bits are dropped.
  logic        if_addr_lo_unused;
  assign if_addr_lo_unused = ^if_addr[1:0];

  // Response pulses come straight from the wait states. An async reset
  // therefore clears them immediately.
  always_comb begin
    if_valid = (state_q == WAIT_IF);
    d_valid  = (state_q == WAIT_D);
  end

  // A port whose response is showing this cycle cannot win again until it has
  // dropped or updated its request.
  always_comb begin
    if_elig   = if_req & ~if_valid;
    d_elig    = d_req  & ~d_valid;
    cpu_stall = if_elig | d_elig;
  end

  // Decode the size of the data request and detect misalignment.
  always_comb begin
    d_size = fn_size(d_fn);
    d_mis  = ((d_size == SZ_H) &&  d_addr[0]) ||
             ((d_size == SZ_W) && (d_addr[1:0] != 2'b00));
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q;

  // Force a fetch grant once four data grants have passed over a waiting fetch.
  always_comb begin
    starve_force = (starve_cnt_q == 3'd4) && if_elig;
  end

  // Count data grants that overtook a pending fetch. Any fetch grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 3'd0;
    end else if (grant_if) begin
      starve_cnt_q <= 3'd0;
    end else if (grant_d && if_elig && (starve_cnt_q != 3'd4)) begin
      starve_cnt_q <= starve_cnt_q + 3'd1;
    end
  end
`else
  always_comb begin
    starve_force = 1'b0;
  end
`endif

  // Arbitration, memory command and next state.
  always_comb begin
    // NOTE: every signal gets a default before any branch. If one path left a
    // signal unassigned, the tool would infer a latch to hold its old value.
    state_d  = IDLE;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_be     = 4'b0000;
    m_addr   = '0;
    m_wdata  = '0;

    if (!reset) begin
      grant_d  = d_elig & ~starve_force;
      grant_if = if_elig & ~grant_d;
    end

    if (grant_d) begin
      state_d = WAIT_D;
      // A misaligned access uses its grant slot but never reaches memory.
      if (!d_mis) begin
        m_en   = 1'b1;
        m_addr = {d_addr[ADDR_LEN-1:2], 2'b00};
        if (d_we) begin
          m_we = 1'b1;
          case (d_size)
            SZ_B: begin
              m_be    = 4'b0001 << d_addr[1:0];
              m_wdata = {4{d_wdata[7:0]}};
            end
            SZ_H: begin
              m_be    = 4'b0011 << d_addr[1:0];
              m_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
              m_be    = 4'b1111;
              m_wdata = d_wdata;
            end
          endcase
        end
      end
    end else if (grant_if) begin
      state_d = WAIT_IF;
      m_en    = 1'b1;
      m_addr  = {if_addr[ADDR_LEN-1:2], 2'b00};
    end
  end

  // State register. Reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment. All flops then
      // sample their inputs from before the edge, whatever order the blocks run in.
      state_q <= state_d;
    end
  end

  // Capture the data-access context that the response cycle will need.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_off_q   <= 2'b00;
      rsp_fn_q    <= 3'b000;
      rsp_store_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
    end else if (grant_d) begin
      rsp_off_q   <= d_addr[1:0];
      rsp_fn_q    <= d_fn;
      rsp_store_q <= d_we;
      rsp_mis_q   <= d_mis;
    end
  end

  // Form the response data: fetch passthrough, then load lane select and extension.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    if_rdata   = if_valid ? m_rdata : '0;
    d_misalign = d_valid & rsp_mis_q;
    d_rdata    = '0;

    case (rsp_off_q)
      2'd0:    lane_b = m_rdata[7:0];
      2'd1:    lane_b = m_rdata[15:8];
      2'd2:    lane_b = m_rdata[23:16];
      default: lane_b = m_rdata[31:24];
    endcase
    lane_h = rsp_off_q[1] ? m_rdata[31:16] : m_rdata[15:0];

    if (d_valid && !rsp_mis_q && !rsp_store_q) begin
      case (rsp_fn_q)
        FN_B:    d_rdata = {{(DATA_LEN-8){lane_b[7]}}, lane_b};
        FN_H:    d_rdata = {{(DATA_LEN-16){lane_h[15]}}, lane_h};
        FN_BU:   d_rdata = {{(DATA_LEN-8){1'b0}}, lane_b};
        FN_HU:   d_rdata = {{(DATA_LEN-16){1'b0}}, lane_h};
        default: d_rdata = m_rdata;
      endcase
    end
  end

endmodule
